// File: rtl/vga_pixel_scanner_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_scanner_if
//   Bundle between the raster timing generator and the overlay blocks that
//   query it.
//
//   Optional feature macro: FRAME_COUNT_EN (adds frame_cnt).
//
//   Signals
//     enable       scan run/freeze request from the consumer side
//     p_tick       one-clk pulse per pixel period
//     pixel_x      current column
//     pixel_y      current line
//     video_on     current position lies inside the visible area
//     hsync        horizontal sync, active low
//     vsync        vertical sync, active low
//     frame_start  one-clk pulse when the scan wraps to (0,0)
//     frame_cnt    completed-frame counter (FRAME_COUNT_EN only)
//
//   Modports
//     master  timing generator side (drives the raster signals)
//     slave   consumer side (drives enable, observes raster signals)
// ---------------------------------------------------------------------------
interface vga_pixel_scanner_if;
  logic       enable;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
`ifdef FRAME_COUNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  enable,
    output p_tick,
    output pixel_x,
    output pixel_y,
    output video_on,
    output hsync,
    output vsync,
`ifdef FRAME_COUNT_EN
    output frame_cnt,
`endif
    output frame_start
  );

  modport slave (
    output enable,
    input  p_tick,
    input  pixel_x,
    input  pixel_y,
    input  video_on,
    input  hsync,
    input  vsync,
`ifdef FRAME_COUNT_EN
    input  frame_cnt,
`endif
    input  frame_start
  );
endinterface

// File: rtl/vga_pixel_scanner.sv
// ---------------------------------------------------------------------------
// vga_pixel_scanner
//   Raster timing generator. Divides the system clock into a pixel tick and
//   scans pixel_x/pixel_y across the whole frame (visible area plus porches
//   and sync), producing hsync, vsync, video_on and frame_start. Overlay
//   blocks compare pixel_x/pixel_y against their own footprint.
//
//   Optional feature macro: FRAME_COUNT_EN
//     defined   -> 8-bit frame_cnt register/port, +1 on every frame_start
//     undefined -> no frame_cnt at all, everything else identical
//
//   Ports
//     clk      in  system clock, rising edge
//     reset_n  in  asynchronous assert, active low
//     scan     vga_pixel_scanner_if.master
//       enable (in)  1 = scan runs, 0 = divider/counters/outputs frozen
//       p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start,
//       frame_cnt (out, FRAME_COUNT_EN only)
//
//   Timing model
//     The pixel counters step on the same edge that raises p_tick, so the
//     cycle in which p_tick is high already shows the new coordinate. A
//     dropped enable therefore never swallows a pending tick: the divider
//     simply stops where it is and resumes from the same value.
//
//   TICK_DIV must be >= 2.
// ---------------------------------------------------------------------------
module vga_pixel_scanner #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_pixel_scanner_if.master scan
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // -------------------------------------------------------------------------
  // State and next-state signals
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_r;
  logic [9:0]       x_r;
  logic [9:0]       y_r;
  logic             p_tick_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             frame_start_r;

  logic             tick_due_s;
  logic             x_wrap_s;
  logic             y_wrap_s;
  logic             frame_wrap_s;
  logic [9:0]       x_next_s;
  logic [9:0]       y_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;

  // Pixel period boundary: the divider sits on its last count while running.
  assign tick_due_s   = scan.enable && (div_r == DIV_LAST);
  assign x_wrap_s     = (x_r == X_LAST);
  assign y_wrap_s     = (y_r == Y_LAST);
  assign frame_wrap_s = tick_due_s && x_wrap_s && y_wrap_s;

  // Next raster position; both wraps resolve in one step so (0,V_TOTAL-1)
  // is never visible between them.
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (tick_due_s) begin
      if (x_wrap_s) begin
        x_next_s = 10'd0;
        if (y_wrap_s) begin
          y_next_s = 10'd0;
        end else begin
          y_next_s = y_r + 10'd1;
        end
      end else begin
        x_next_s = x_r + 10'd1;
        y_next_s = y_r;
      end
    end else begin
      x_next_s = x_r;
      y_next_s = y_r;
    end
  end

  // Sync levels for the position about to be loaded, so the registered
  // sync pulses line up with the registered counters.
  always_comb begin
    hsync_next_s = ~in_window(x_next_s, HS_FIRST, HS_LAST);
    vsync_next_s = ~in_window(y_next_s, VS_FIRST, VS_LAST);
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------

  // Clock divider: counts 0..TICK_DIV-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= DIV_ZERO;
    end else if (scan.enable) begin
      if (div_r == DIV_LAST) begin
        div_r <= DIV_ZERO;
      end else begin
        div_r <= div_r + DIV_ONE;
      end
    end else begin
      div_r <= div_r;
    end
  end

  // Pixel tick pulse: one clk per period, forced low while frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_tick_r <= 1'b0;
    end else begin
      p_tick_r <= tick_due_s;
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r <= 10'd0;
      y_r <= 10'd0;
    end else begin
      x_r <= x_next_s;
      y_r <= y_next_s;
    end
  end

  // Sync outputs: only move on a pixel step, hold while frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (tick_due_s) begin
      hsync_r <= hsync_next_s;
      vsync_r <= vsync_next_s;
    end else begin
      hsync_r <= hsync_r;
      vsync_r <= vsync_r;
    end
  end

  // Frame start pulse on the step that lands on (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_wrap_s;
    end
  end

`ifdef FRAME_COUNT_EN
  logic [7:0] frame_cnt_r;

  // Completed-frame counter, free-running 8-bit wrap (used for blinking).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign scan.frame_cnt = frame_cnt_r;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign scan.p_tick      = p_tick_r;
  assign scan.pixel_x     = x_r;
  assign scan.pixel_y     = y_r;
  assign scan.hsync       = hsync_r;
  assign scan.vsync       = vsync_r;
  assign scan.frame_start = frame_start_r;
  // Decoded straight from the counters so it has no lag against them.
  assign scan.video_on    = (x_r < X_VIS) && (y_r < Y_VIS);

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner: one instance at the default 640x480 timing
// and one tiny-raster instance whose frames are short enough to cover
// vsync, frame_start spacing and the frame_cnt wrap. Both share clock,
// reset and enable history, so one count of enabled edges (e) describes
// both; expected values come from plain arithmetic on that count.
module tb_vga_pixel_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  vga_pixel_scanner_if full_if();
  vga_pixel_scanner_if small_if();

  vga_pixel_scanner dut_full (
    .clk     (clk),
    .reset_n (reset_n),
    .scan    (full_if.master)
  );

  vga_pixel_scanner #(
    .TICK_DIV(2), .H_DISPLAY(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .scan    (small_if.master)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;     // enabled clock edges since reset
  bit last_en = 1'b0; // was the most recent edge an enabled one

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d (e=%0d)", tag, obs, exp, e);
    end
  endtask

  // Reference: n pixel periods have elapsed; position, syncs and pulses
  // follow from n by division and remainder.
  task automatic check_one(input string nm, input int div,
                           input int hd, input int hfp, input int hsw, input int hbp,
                           input int vd, input int vfp, input int vsw, input int vbp,
                           input logic pt, input logic [9:0] px, input logic [9:0] py,
                           input logic von, input logic hs, input logic vs,
                           input logic fs, input logic [7:0] fc);
    int ht, vt, n, x, y, frames;
    logic ept, efs;
    ht = hd + hfp + hsw + hbp;
    vt = vd + vfp + vsw + vbp;
    n  = e / div;
    x  = n % ht;
    y  = (n / ht) % vt;
    frames = n / (ht * vt);
    ept = last_en && (e > 0) && (e % div == 0);
    efs = ept && (x == 0) && (y == 0);
    chk({nm, ".p_tick"},   32'(pt),  32'(ept));
    chk({nm, ".pixel_x"},  32'(px),  32'(x));
    chk({nm, ".pixel_y"},  32'(py),  32'(y));
    chk({nm, ".video_on"}, 32'(von), 32'((x < hd) && (y < vd)));
    chk({nm, ".hsync"},    32'(hs),  32'(!((x >= hd + hfp) && (x < hd + hfp + hsw))));
    chk({nm, ".vsync"},    32'(vs),  32'(!((y >= vd + vfp) && (y < vd + vfp + vsw))));
    chk({nm, ".frame_start"}, 32'(fs), 32'(efs));
`ifdef FRAME_COUNT_EN
    chk({nm, ".frame_cnt"}, 32'(fc), 32'(frames % 256));
`endif
  endtask

  task automatic check_all();
    logic [7:0] fc_full, fc_small;
`ifdef FRAME_COUNT_EN
    fc_full  = full_if.frame_cnt;
    fc_small = small_if.frame_cnt;
`else
    fc_full  = 8'd0;
    fc_small = 8'd0;
`endif
    check_one("full", 4, 640, 16, 96, 48, 480, 10, 2, 33,
              full_if.p_tick, full_if.pixel_x, full_if.pixel_y, full_if.video_on,
              full_if.hsync, full_if.vsync, full_if.frame_start, fc_full);
    check_one("small", 2, 4, 1, 2, 1, 4, 1, 1, 1,
              small_if.p_tick, small_if.pixel_x, small_if.pixel_y, small_if.video_on,
              small_if.hsync, small_if.vsync, small_if.frame_start, fc_small);
  endtask

  // One clock with the given enable, then compare both instances.
  task automatic step(input logic en);
    full_if.enable  = en;
    small_if.enable = en;
    @(posedge clk);
    if (!reset_n) begin
      e = 0;
      last_en = 1'b0;
    end else begin
      if (en) e++;
      last_en = en;
    end
    #1;
    check_all();
  endtask

  initial begin
    int hs_low, vis, last_fs, nper;
    reset_n = 1'b0;
    full_if.enable  = 1'b0;
    small_if.enable = 1'b0;

    // Reset state.
    repeat (3) step(1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-scan reset at pixel_x = 300.
    repeat (1200) step(1'b1);
    chk("pre_reset_x", 32'(full_if.pixel_x), 32'd300);
    #2;
    reset_n = 1'b0;
    #1;
    e = 0;
    last_en = 1'b0;
    chk("async_rst_x",      32'(full_if.pixel_x), 32'd0);
    chk("async_rst_y",      32'(full_if.pixel_y), 32'd0);
    chk("async_rst_hsync",  32'(full_if.hsync),   32'd1);
    chk("async_rst_vsync",  32'(full_if.vsync),   32'd1);
    chk("async_rst_p_tick", 32'(full_if.p_tick),  32'd0);
    check_all();
    repeat (2) step(1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Freeze at pixel_x = 100 with the divider mid-period.
    repeat (402) step(1'b1);
    chk("freeze_at_x", 32'(full_if.pixel_x), 32'd100);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk("frozen_p_tick", 32'(full_if.p_tick),  32'd0);
      chk("frozen_x",      32'(full_if.pixel_x), 32'd100);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      if (full_if.p_tick) break;
    end
    chk("resume_tick_seen", 32'(full_if.p_tick),  32'd1);
    chk("resume_x",         32'(full_if.pixel_x), 32'd101);

    // First line ends after 3200 enabled clks.
    while (e < 3200) step(1'b1);
    chk("line_wrap_x",      32'(full_if.pixel_x), 32'd0);
    chk("line_wrap_y",      32'(full_if.pixel_y), 32'd1);
    chk("line_wrap_p_tick", 32'(full_if.p_tick),  32'd1);

    // Second line: count pixel periods with hsync low and with video_on.
    hs_low = 0;
    vis = 0;
    while (e < 6400) begin
      step(1'b1);
      if (full_if.p_tick && !full_if.hsync)  hs_low++;
      if (full_if.p_tick && full_if.video_on) vis++;
    end
    chk("hsync_low_ticks", 32'(hs_low), 32'd96);
    chk("video_on_ticks",  32'(vis),    32'd640);

    // Random enable pattern.
    for (int i = 0; i < 8000; i++) step($urandom_range(0, 7) != 0);

    // Continuous scan: small-raster frames every 56 ticks = 112 clks;
    // runs well past 256 frames so frame_cnt wraps.
    last_fs = -1;
    nper = 0;
    for (int i = 0; i < 30000; i++) begin
      step(1'b1);
      if (small_if.frame_start) begin
        if (last_fs >= 0 && nper < 4) begin
          chk("frame_period", 32'(i - last_fs), 32'd112);
          nper++;
        end
        last_fs = i;
      end
    end
    chk("frame_period_seen", 32'(nper), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
